// File: rtl/fir_decim_fifo.sv
// Decimator behind the 9-tap FIR: drops pipeline warm-up samples, keeps one sample in
// every DECIM, and buffers kept samples in a first-word-fall-through FIFO.
module fir_decim_fifo #(
    parameter int N      = 24,
    parameter int DECIM  = 4,
    parameter int WARMUP = 10,
    parameter int DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic signed [N-1:0]          data_in,
    output logic signed [N-1:0]          out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PHASE = PW'(DECIM - 1);
    localparam logic [WW-1:0] WARM_INIT  = WW'(WARMUP);

    logic [N-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_phase;
    logic [WW-1:0] r_warm;
    logic          r_overflow;

    logic w_warming;
    logic w_full;
    logic w_wr_req;
    logic w_rd;
    logic w_wr;

    // Valid/ready: a sample leaves the FIFO on every clock edge where out_valid and
    // out_ready are both high; out_data is stable while out_valid is high and not taken.
    assign w_warming = (r_warm != '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_wr_req  = in_valid && !w_warming && (r_phase == '0) && !clear;
    assign w_rd      = out_valid && out_ready && !clear;
    // A full FIFO still accepts a write when the head is being read in the same cycle.
    assign w_wr      = w_wr_req && (!w_full || w_rd);

    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign overflow  = r_overflow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_phase    <= '0;
            r_warm     <= WARM_INIT;
            r_overflow <= 1'b0;
        end else if (clear) begin
            // The warm-up counter is deliberately left alone: the FIR pipeline is still primed.
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_phase    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (in_valid) begin
                if (w_warming) begin
                    r_warm <= r_warm - 1'b1;
                end else begin
                    r_phase <= (r_phase == LAST_PHASE) ? '0 : r_phase + 1'b1;
                end
            end
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd && !w_wr) begin
                r_count <= r_count - 1'b1;
            end
            if (w_wr_req && w_full && !w_rd) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
